// File: rtl/hyper_tx_sched.sv
// hyper_tx_sched
// Two-channel transmit scheduler in front of a HyperBus TX buffer.
// A round-robin arbiter accepts one command at a time from channel 0 or 1.
// The accepted command fields are latched onto the buffer configuration
// outputs. The granted channel's data stream is then routed to the buffer
// until the byte count is exhausted. The block then waits for the PHY to
// report end of transaction and pulses the owning channel's done output.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   chN_cmd_valid_i / chN_cmd_ready_o command handshake per channel
//   chN_addr_space_i, chN_burst_type_i, chN_mem_sel_i, chN_odd_i, chN_len_i
//                                     command fields (len in bytes)
//   chN_data_valid_i / chN_data_i / chN_data_ready_o  per-channel data stream
//   buf_valid_o / buf_data_o / buf_ready_i            buffer-side data stream
//   buf_dst_ready_o                   PHY enable (high while a transfer is open)
//   mem_sel_o, cfg_addr_space_o, burst_type_o, hyper_odd_saaddr_o,
//   remained_data_o                   latched configuration / bytes remaining
//   phy_done_i, abort_i               PHY end-of-transaction pulse, abort
//   chN_done_o, busy_o, grant_o       completion pulses, busy, owning channel
//   state_dbg_o                       current FSM state, for observation only
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. Valid never depends on ready. Ready may be high
// without valid.
module hyper_tx_sched #(
   parameter int TRANS_SIZE = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ch0_cmd_valid_i,
   output logic                  ch0_cmd_ready_o,
   input  logic                  ch0_addr_space_i,
   input  logic                  ch0_burst_type_i,
   input  logic [1:0]            ch0_mem_sel_i,
   input  logic                  ch0_odd_i,
   input  logic [TRANS_SIZE-1:0] ch0_len_i,
   input  logic                  ch0_data_valid_i,
   input  logic [31:0]           ch0_data_i,
   output logic                  ch0_data_ready_o,
   input  logic                  ch1_cmd_valid_i,
   output logic                  ch1_cmd_ready_o,
   input  logic                  ch1_addr_space_i,
   input  logic                  ch1_burst_type_i,
   input  logic [1:0]            ch1_mem_sel_i,
   input  logic                  ch1_odd_i,
   input  logic [TRANS_SIZE-1:0] ch1_len_i,
   input  logic                  ch1_data_valid_i,
   input  logic [31:0]           ch1_data_i,
   output logic                  ch1_data_ready_o,
   output logic                  buf_valid_o,
   output logic [31:0]           buf_data_o,
   input  logic                  buf_ready_i,
   output logic                  buf_dst_ready_o,
   output logic [1:0]            mem_sel_o,
   output logic                  cfg_addr_space_o,
   output logic                  burst_type_o,
   output logic                  hyper_odd_saaddr_o,
   output logic [TRANS_SIZE-1:0] remained_data_o,
   input  logic                  phy_done_i,
   input  logic                  abort_i,
   output logic                  ch0_done_o,
   output logic                  ch1_done_o,
   output logic                  busy_o,
   output logic                  grant_o,
   output logic [1:0]            state_dbg_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [TRANS_SIZE-1:0] BEAT_BYTES = TRANS_SIZE'(4);

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant_q, grant_d;
   logic [1:0]            mem_sel_q, mem_sel_d;
   logic                  addr_space_q, addr_space_d;
   logic                  burst_type_q, burst_type_d;
   logic                  odd_q, odd_d;
   logic [TRANS_SIZE-1:0] rem_q, rem_d;
   logic [1:0]            done_q, done_d;

   logic                  winner;
   logic                  accept;
   logic                  beat;
   logic                  sel_addr_space;
   logic                  sel_burst_type;
   logic [1:0]            sel_mem_sel;
   logic                  sel_odd;
   logic [TRANS_SIZE-1:0] sel_len;

   // Round robin: on contention the channel that did not win last time wins.
   // With no contention, channel 1 wins only if it is the sole requester.
   always_comb begin
      if (ch0_cmd_valid_i && ch1_cmd_valid_i) begin
         winner = ~last_grant_q;
      end else begin
         winner = ch1_cmd_valid_i;
      end
   end

   assign ch0_cmd_ready_o = (state_q == IDLE) && (winner == 1'b0);
   assign ch1_cmd_ready_o = (state_q == IDLE) && (winner == 1'b1);
   assign accept = (state_q == IDLE) && (winner ? ch1_cmd_valid_i : ch0_cmd_valid_i);

   assign sel_addr_space = winner ? ch1_addr_space_i : ch0_addr_space_i;
   assign sel_burst_type = winner ? ch1_burst_type_i : ch0_burst_type_i;
   assign sel_mem_sel    = winner ? ch1_mem_sel_i    : ch0_mem_sel_i;
   assign sel_odd        = winner ? ch1_odd_i        : ch0_odd_i;
   assign sel_len        = winner ? ch1_len_i        : ch0_len_i;

   // Data routing: only the granted channel is connected, and only in XFER.
   always_comb begin
      buf_valid_o      = 1'b0;
      buf_data_o       = '0;
      ch0_data_ready_o = 1'b0;
      ch1_data_ready_o = 1'b0;
      if (state_q == XFER) begin
         if (grant_q) begin
            buf_valid_o      = ch1_data_valid_i;
            buf_data_o       = ch1_data_i;
            ch1_data_ready_o = buf_ready_i;
         end else begin
            buf_valid_o      = ch0_data_valid_i;
            buf_data_o       = ch0_data_i;
            ch0_data_ready_o = buf_ready_i;
         end
      end
   end

   assign beat = (state_q == XFER) && buf_valid_o && buf_ready_i;

   // Next-state logic. Abort beats everything except reset. An abort in IDLE
   // also drops any command offered in that cycle. Done is registered, so
   // the pulse shows up in the first IDLE cycle. This keeps phy_done_i off
   // every combinational output path.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      mem_sel_d    = mem_sel_q;
      addr_space_d = addr_space_q;
      burst_type_d = burst_type_q;
      odd_d        = odd_q;
      rem_d        = rem_q;
      done_d       = 2'b00;
      if (abort_i) begin
         state_d = IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  mem_sel_d    = sel_mem_sel;
                  addr_space_d = sel_addr_space;
                  burst_type_d = sel_burst_type;
                  odd_d        = sel_odd;
                  rem_d        = sel_len;
                  grant_d      = winner;
                  last_grant_d = winner;
                  // Register accesses and empty transfers carry no data beats.
                  if (sel_addr_space || (sel_len == '0)) begin
                     state_d = DRAIN;
                  end else begin
                     state_d = XFER;
                  end
               end
            end
            XFER: begin
               if (beat) begin
                  // Saturating decrement: a non-multiple-of-4 tail counts as a full beat.
                  if (rem_q > BEAT_BYTES) begin
                     rem_d = rem_q - BEAT_BYTES;
                  end else begin
                     rem_d   = '0;
                     state_d = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (phy_done_i) begin
                  state_d         = IDLE;
                  done_d[grant_q] = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         mem_sel_q    <= 2'b00;
         addr_space_q <= 1'b0;
         burst_type_q <= 1'b0;
         odd_q        <= 1'b0;
         rem_q        <= '0;
         done_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         mem_sel_q    <= mem_sel_d;
         addr_space_q <= addr_space_d;
         burst_type_q <= burst_type_d;
         odd_q        <= odd_d;
         rem_q        <= rem_d;
         done_q       <= done_d;
      end
   end

   assign mem_sel_o          = mem_sel_q;
   assign cfg_addr_space_o   = addr_space_q;
   assign burst_type_o       = burst_type_q;
   assign hyper_odd_saaddr_o = odd_q;
   assign remained_data_o    = rem_q;
   assign grant_o            = grant_q;
   assign ch0_done_o         = done_q[0];
   assign ch1_done_o         = done_q[1];
   assign busy_o             = (state_q != IDLE);
   assign buf_dst_ready_o    = (state_q != IDLE);
   assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_hyper_tx_sched.sv
module tb_hyper_tx_sched;

  localparam int TS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ch0_cmd_valid, ch1_cmd_valid, ch0_cmd_ready, ch1_cmd_ready;
  logic          ch0_as, ch1_as, ch0_bt, ch1_bt, ch0_odd, ch1_odd;
  logic [1:0]    ch0_ms, ch1_ms;
  logic [TS-1:0] ch0_len, ch1_len;
  logic          ch0_dv, ch1_dv, ch0_dr, ch1_dr;
  logic [31:0]   ch0_d, ch1_d;
  logic          buf_valid, buf_ready, buf_dst_ready;
  logic [31:0]   buf_data;
  logic [1:0]    mem_sel;
  logic          cfg_as, burst_type, odd_sa;
  logic [TS-1:0] remained;
  logic          phy_done, abort;
  logic          ch0_done, ch1_done, busy, grant;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: channel expected to report done, in acceptance order
  logic [0:0] exp_q[$];

  // reference model: transaction-level view
  int   m_phase;          // 0 = no transfer, 1 = moving data, 2 = waiting for PHY
  logic m_last, m_grant, m_as, m_bt, m_odd;
  logic [1:0] m_ms, m_done;
  int   m_len, m_rem, m_beats_total, m_beats_done;

  hyper_tx_sched #(.TRANS_SIZE(TS)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch0_cmd_valid_i(ch0_cmd_valid), .ch0_cmd_ready_o(ch0_cmd_ready),
    .ch0_addr_space_i(ch0_as), .ch0_burst_type_i(ch0_bt), .ch0_mem_sel_i(ch0_ms),
    .ch0_odd_i(ch0_odd), .ch0_len_i(ch0_len),
    .ch0_data_valid_i(ch0_dv), .ch0_data_i(ch0_d), .ch0_data_ready_o(ch0_dr),
    .ch1_cmd_valid_i(ch1_cmd_valid), .ch1_cmd_ready_o(ch1_cmd_ready),
    .ch1_addr_space_i(ch1_as), .ch1_burst_type_i(ch1_bt), .ch1_mem_sel_i(ch1_ms),
    .ch1_odd_i(ch1_odd), .ch1_len_i(ch1_len),
    .ch1_data_valid_i(ch1_dv), .ch1_data_i(ch1_d), .ch1_data_ready_o(ch1_dr),
    .buf_valid_o(buf_valid), .buf_data_o(buf_data), .buf_ready_i(buf_ready),
    .buf_dst_ready_o(buf_dst_ready),
    .mem_sel_o(mem_sel), .cfg_addr_space_o(cfg_as), .burst_type_o(burst_type),
    .hyper_odd_saaddr_o(odd_sa), .remained_data_o(remained),
    .phy_done_i(phy_done), .abort_i(abort),
    .ch0_done_o(ch0_done), .ch1_done_o(ch1_done), .busy_o(busy), .grant_o(grant),
    .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    ch0_cmd_valid = 0; ch1_cmd_valid = 0;
    ch0_as = 0; ch1_as = 0; ch0_bt = 0; ch1_bt = 0; ch0_odd = 0; ch1_odd = 0;
    ch0_ms = 0; ch1_ms = 0; ch0_len = 0; ch1_len = 0;
    ch0_dv = 0; ch1_dv = 0; ch0_d = 0; ch1_d = 0;
    buf_ready = 0; phy_done = 0; abort = 0; rst = 0;
  endtask

  task automatic set_cmd(input int ch, input logic as_v, input logic bt_v,
                         input logic [1:0] ms_v, input logic odd_v, input int len_v);
    if (ch == 0) begin
      ch0_cmd_valid = 1; ch0_as = as_v; ch0_bt = bt_v; ch0_ms = ms_v;
      ch0_odd = odd_v; ch0_len = TS'(len_v);
    end else begin
      ch1_cmd_valid = 1; ch1_as = as_v; ch1_bt = bt_v; ch1_ms = ms_v;
      ch1_odd = odd_v; ch1_len = TS'(len_v);
    end
  endtask

  // Called right after a falling edge with inputs already driven: compares
  // every output against the model, advances the model by one clock, and
  // returns at the following falling edge.
  task automatic cycle();
    logic [1:0] req;
    logic win, exp_bv, exp_dr0, exp_dr1;
    logic [31:0] exp_bd;
    #1;
    req = {ch1_cmd_valid, ch0_cmd_valid};
    win = (req == 2'b11) ? ~m_last : req[1];
    exp_bv = 0; exp_dr0 = 0; exp_dr1 = 0; exp_bd = 0;
    if (m_phase == 1) begin
      exp_bv  = m_grant ? ch1_dv : ch0_dv;
      exp_bd  = m_grant ? ch1_d : ch0_d;
      exp_dr0 = !m_grant && buf_ready;
      exp_dr1 = m_grant && buf_ready;
    end
    check("busy", busy, m_phase != 0);
    check("dst_ready", buf_dst_ready, m_phase != 0);
    check("cmd_ready0", ch0_cmd_ready, m_phase == 0 && win == 0);
    check("cmd_ready1", ch1_cmd_ready, m_phase == 0 && win == 1);
    check("buf_valid", buf_valid, exp_bv);
    if (exp_bv) check("buf_data", buf_data, exp_bd);
    check("data_ready0", ch0_dr, exp_dr0);
    check("data_ready1", ch1_dr, exp_dr1);
    check("remained", remained, m_rem);
    check("grant", grant, m_grant);
    check("mem_sel", mem_sel, m_ms);
    check("addr_space", cfg_as, m_as);
    check("burst_type", burst_type, m_bt);
    check("odd", odd_sa, m_odd);
    check("done", {ch1_done, ch0_done}, m_done);
    if (ch0_done || ch1_done) begin
      if (exp_q.size() == 0) check("done_unexpected", 1, 0);
      else check("done_channel", ch1_done, exp_q.pop_front());
    end
    // model step
    if (rst) begin
      m_phase = 0; m_last = 1; m_grant = 0; m_ms = 0; m_as = 0; m_bt = 0;
      m_odd = 0; m_rem = 0; m_done = 0; exp_q.delete();
    end else if (abort) begin
      if (m_phase != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
      m_phase = 0; m_rem = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_phase)
        0: if (req[win]) begin
          m_grant = win; m_last = win;
          m_as  = win ? ch1_as : ch0_as;
          m_bt  = win ? ch1_bt : ch0_bt;
          m_ms  = win ? ch1_ms : ch0_ms;
          m_odd = win ? ch1_odd : ch0_odd;
          m_len = win ? int'(ch1_len) : int'(ch0_len);
          m_rem = m_len;
          m_beats_total = (m_len + 3) / 4;
          m_beats_done = 0;
          m_phase = (m_as || m_len == 0) ? 2 : 1;
          exp_q.push_back(win);
        end
        1: if (exp_bv && buf_ready) begin
          m_beats_done++;
          m_rem = m_len - 4 * m_beats_done;
          if (m_rem < 0) m_rem = 0;
          if (m_beats_done == m_beats_total) m_phase = 2;
        end
        default: if (phy_done) begin
          m_phase = 0;
          m_done = 2'b01 << m_grant;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  initial begin
    int guard;
    idle_inputs();
    m_phase = 0; m_last = 1; m_grant = 0; m_ms = 0; m_as = 0; m_bt = 0;
    m_odd = 0; m_rem = 0; m_done = 0; m_len = 0; m_beats_total = 0; m_beats_done = 0;
    @(negedge clk);
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_remained", remained, 0);

    // single memory write: ch0 len 8, two beats
    set_cmd(0, 0, 1, 2'd3, 0, 8); buf_ready = 1; ch0_dv = 1; ch0_d = 32'hA5A5_0001;
    cycle();
    ch0_cmd_valid = 0;
    check("w_rem8", remained, 8);
    check("w_mem_sel", mem_sel, 3);
    cycle(); check("w_rem4", remained, 4);
    ch0_d = 32'hA5A5_0002;
    cycle(); check("w_rem0", remained, 0);
    check("w_drain_busy", busy, 1);
    cycle();
    phy_done = 1; cycle(); phy_done = 0;
    check("w_done0", ch0_done, 1);
    check("w_idle", busy, 0);
    cycle();
    check("w_done_once", ch0_done, 0);

    // contention from reset: grants alternate 0,1,0,1
    idle_inputs(); do_reset();
    set_cmd(0, 0, 0, 2'd1, 0, 4); set_cmd(1, 0, 1, 2'd2, 1, 4);
    ch0_dv = 1; ch1_dv = 1; ch0_d = 32'h0000_00C0; ch1_d = 32'h0000_00C1;
    buf_ready = 1; phy_done = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rr_grant", grant, k % 2);
      cycle(); cycle();
    end
    idle_inputs(); cycle(); cycle();

    // register access on ch1: no data beats
    set_cmd(1, 1, 0, 2'd0, 1, 2); ch1_dv = 1; buf_ready = 1;
    cycle(); ch1_cmd_valid = 0;
    check("reg_as", cfg_as, 1);
    check("reg_drain", state_dbg, 2);
    cycle();
    phy_done = 1; cycle(); phy_done = 0;
    check("reg_done1", ch1_done, 1);
    cycle();

    // odd length with toggling backpressure
    idle_inputs();
    set_cmd(0, 0, 0, 2'd2, 1, 6); ch0_dv = 1;
    cycle(); ch0_cmd_valid = 0;
    guard = 0;
    while (m_phase == 1 && guard < 40) begin
      buf_ready = guard[0]; ch0_d = $urandom; cycle(); guard++;
    end
    if (m_phase == 1) check("odd_timeout", 1, 0);
    check("odd_rem0", remained, 0);
    phy_done = 1; cycle(); idle_inputs(); cycle();

    // abort in XFER with 12 bytes remaining
    set_cmd(0, 0, 0, 2'd1, 0, 12); ch0_dv = 1;
    cycle(); ch0_cmd_valid = 0;
    check("ab_rem12", remained, 12);
    abort = 1; cycle(); abort = 0;
    check("ab_idle", busy, 0);
    check("ab_rem0", remained, 0);
    cycle();

    // reset in DRAIN
    set_cmd(1, 1, 1, 2'd3, 1, 0); cycle(); ch1_cmd_valid = 0; cycle();
    rst = 1; cycle(); rst = 0;
    check("rst_mem_sel", mem_sel, 0);
    check("rst_dst", buf_dst_ready, 0);
    check("rst_as", cfg_as, 0);

    // abort together with phy_done in DRAIN
    set_cmd(0, 1, 0, 2'd1, 0, 4); cycle(); ch0_cmd_valid = 0; cycle();
    abort = 1; phy_done = 1; cycle(); abort = 0; phy_done = 0;
    check("abpd_nodone", {ch1_done, ch0_done}, 0);
    check("abpd_idle", busy, 0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ch0_cmd_valid = $urandom_range(0, 1); ch1_cmd_valid = $urandom_range(0, 1);
      ch0_as = ($urandom_range(0, 7) == 0); ch1_as = ($urandom_range(0, 7) == 0);
      ch0_bt = $urandom_range(0, 1); ch1_bt = $urandom_range(0, 1);
      ch0_odd = $urandom_range(0, 1); ch1_odd = $urandom_range(0, 1);
      ch0_ms = 2'($urandom_range(0, 3)); ch1_ms = 2'($urandom_range(0, 3));
      ch0_len = TS'($urandom_range(0, 20)); ch1_len = TS'($urandom_range(0, 20));
      ch0_dv = $urandom_range(0, 3) != 0; ch1_dv = $urandom_range(0, 3) != 0;
      ch0_d = $urandom; ch1_d = $urandom;
      buf_ready = $urandom_range(0, 3) != 0;
      phy_done = $urandom_range(0, 3) == 0;
      abort = (m_phase != 0) && ($urandom_range(0, 29) == 0);
      rst = $urandom_range(0, 199) == 0;
      cycle();
    end

    // let any open transaction finish, then every done must have arrived
    idle_inputs(); ch0_dv = 1; ch1_dv = 1; buf_ready = 1; phy_done = 1;
    guard = 0;
    while (m_phase != 0 && guard < 40) begin cycle(); guard++; end
    if (m_phase != 0) check("final_timeout", 1, 0);
    cycle();
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
